hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_LATENCY, default 4, giving the multi-cycle unit busy length in cycles (legal range 2..15).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 RsD, RtD  input  5 each  source registers of the D-stage instruction.
REQ-005 RsE, RtE  input  5 each  source registers of the E-stage instruction.
REQ-006 WriteRegE, WriteRegM, WriteRegW  input  5 each  destination registers in E, M and W.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enables in E, M and W.
REQ-008 MemtoRegE, MemtoRegM  input  1 each  load indicators in E and M.
REQ-009 BranchD  input  1  branch in D; compared in D.
REQ-010 MultiCycleD, MultiCycleE  input  1 each  multi-cycle op (mul/div) in D and E.
REQ-011 StallF, StallD  output  1 each  hold the PC and the IF/ID register.
REQ-012 FlushE  output  1  clears the ID/EX register; its flush input is synchronous.
REQ-013 ForwardAE, ForwardBE  output  2 each  E-stage operand select: 00 = register file, 01 = W result, 10 = M result.
REQ-014 ForwardAD, ForwardBD  output  1 each  D-stage branch-compare operand taken from M.
REQ-015 McBusy  output  1  multi-cycle unit occupied.
REQ-016 McDone  output  1  last busy cycle of the multi-cycle unit.

Function
REQ-017 A destination of register 0 SHALL never cause a hazard, forward or stall.
REQ-018 ForwardAE SHALL be 10 when RegWriteM and WriteRegM==RsE. Otherwise it SHALL be 01 when RegWriteW and WriteRegW==RsE. Otherwise it SHALL be 00. M takes priority over W.
REQ-019 ForwardBE SHALL follow the rule of REQ-018 using RtE.
REQ-020 ForwardAD SHALL be RegWriteM and WriteRegM==RsD. ForwardBD SHALL be RegWriteM and WriteRegM==RtD.
REQ-021 lwstall SHALL be MemtoRegE and RegWriteE with WriteRegE matching RsD or RtD.
REQ-022 branchstall SHALL be BranchD together with either RegWriteE and WriteRegE matching RsD or RtD, or MemtoRegM and WriteRegM matching RsD or RtD.
REQ-023 Pending destination SHALL be the latched McDest while BUSY; it SHALL be WriteRegE when IDLE and MultiCycleE is high.
REQ-024 mcstall SHALL be asserted while a multi-cycle op is pending and either RsD or RtD equals the pending destination, or MultiCycleD is high.
REQ-025 StallF, StallD and FlushE SHALL all equal lwstall OR branchstall OR mcstall, combinationally, with zero-cycle latency.
REQ-026 The FSM SHALL have states IDLE and BUSY.
REQ-027 In IDLE with MultiCycleE high, the FSM SHALL move to BUSY on the next edge, load cnt with MC_LATENCY-1 and latch WriteRegE into McDest.
REQ-028 In BUSY, cnt SHALL decrement each edge. When cnt==0, McDone SHALL be 1 and the FSM SHALL return to IDLE on the next edge.
REQ-029 McBusy SHALL be high for exactly MC_LATENCY cycles per operation.
REQ-030 MultiCycleE arriving while BUSY SHALL be ignored; mcstall makes this case unreachable.
REQ-031 cnt SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-032 On reset low, the FSM SHALL go to IDLE and cnt and McDest SHALL clear to 0, immediately and independently of clk. This applies mid-operation too.
REQ-033 While reset is low, McBusy and McDone SHALL be 0. The combinational outputs SHALL reflect only the current inputs.

Configuration
REQ-034 With HAZARD_PERF_EN defined, the block SHALL add outputs StallCount[15:0] and FlushBranchCount[15:0], both saturating at 0xFFFF and cleared by reset.
REQ-035 StallCount SHALL increment on each cycle with StallD high. FlushBranchCount SHALL increment on each cycle with branchstall high.
REQ-036 Without HAZARD_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 The shared package hazard_pkg SHALL hold the forward-select constants (FWD_RF, FWD_WB, FWD_MEM), the FSM state type and the default MC_LATENCY.
REQ-038 The FSM, cnt and McDest SHALL live in sub-module mc_scoreboard. The forwarding and stall logic SHALL stay in hazard_ctrl.

Verification
REQ-039 Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=5, RsD=5 -> StallF=StallD=FlushE=1; with WriteRegE=0 -> all 0.
REQ-040 Forwarding priority: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=7, RsE=7 -> ForwardAE=10; with RegWriteM=0 -> 01.
REQ-041 Branch: BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3 -> stall for 1 cycle; next cycle RegWriteM=1, WriteRegM=3 -> ForwardBD=1 and no stall.
REQ-042 Multi-cycle: MultiCycleE=1, WriteRegE=9, MC_LATENCY=4 -> McBusy high 4 cycles, McDone on the 4th; RsD=9 during this window stalls until McBusy falls.
REQ-043 Reset mid-op: drop reset in the 2nd BUSY cycle -> McBusy=0 immediately; RsD=9 no longer stalls.
REQ-044 HAZARD_PERF_EN: 3 load-use stall cycles -> StallCount=3; forced count 0xFFFF plus one more stall -> remains 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard unit: forward-select encodings,
// multi-cycle scoreboard state type and default multi-cycle latency.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  // E-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Default busy length of the multi-cycle unit, in cycles (legal 2..15)
  localparam int MC_LATENCY_DEFAULT = 4;

  // Multi-cycle scoreboard states
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // A producer/consumer match that can never fire on register 0
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_mc_scoreboard.sv
//------------------------------------------------------------------------------
// mc_scoreboard
// Tracks the single in-flight multi-cycle operation: busy counter, latched
// destination register and the currently pending destination seen by D.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MultiCycleE,
  input  logic [4:0] WriteRegE,
  output logic       McBusy,
  output logic       McDone,
  output logic       PendValid,
  output logic [4:0] PendDest
);

  localparam logic [3:0] CNT_LOAD = 4'(MC_LATENCY - 1);

  mc_state_t  state_q;
  logic [3:0] cnt_q;
  logic [4:0] mc_dest_q;

  // Scoreboard FSM: a new op is accepted only from IDLE; BUSY counts down to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MC_IDLE;
      cnt_q     <= 4'd0;
      mc_dest_q <= 5'd0;
    end else begin
      case (state_q)
        MC_IDLE: begin
          if (MultiCycleE) begin
            state_q   <= MC_BUSY;
            cnt_q     <= CNT_LOAD;
            mc_dest_q <= WriteRegE;
          end
        end
        MC_BUSY: begin
          // MultiCycleE here is ignored; D-stage stalling keeps it from happening
          if (cnt_q == 4'd0) begin
            state_q <= MC_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  // Status decoded purely from state registers, so reset forces them low at once
  always_comb begin
    McBusy    = (state_q == MC_BUSY);
    McDone    = (state_q == MC_BUSY) && (cnt_q == 4'd0);
    // An op entering E is already pending before it is latched
    PendValid = (state_q == MC_BUSY) || MultiCycleE;
    PendDest  = (state_q == MC_BUSY) ? mc_dest_q : WriteRegE;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl
// Five-stage pipeline hazard unit: E- and D-stage forwarding selects, load-use,
// branch and multi-cycle stall detection, plus multi-cycle unit tracking.
// Optional macro HAZARD_PERF_EN adds saturating StallCount/FlushBranchCount.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        MultiCycleD,
  input  logic        MultiCycleE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        McBusy,
  output logic        McDone
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] FlushBranchCount
`endif
);

  logic       pend_valid;
  logic [4:0] pend_dest;
  logic       lwstall;
  logic       branchstall;
  logic       mcstall;
  logic       stall;

  mc_scoreboard #(
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .MultiCycleE (MultiCycleE),
    .WriteRegE   (WriteRegE),
    .McBusy      (McBusy),
    .McDone      (McDone),
    .PendValid   (pend_valid),
    .PendDest    (pend_dest)
  );

  // Forwarding selects: the younger M result wins over W
  always_comb begin
    if (reg_hit(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_MEM;
    else if (reg_hit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_WB;
    else                                         ForwardAE = FWD_RF;

    if (reg_hit(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_MEM;
    else if (reg_hit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_WB;
    else                                         ForwardBE = FWD_RF;

    ForwardAD = reg_hit(RegWriteM, WriteRegM, RsD);
    ForwardBD = reg_hit(RegWriteM, WriteRegM, RtD);
  end

  // Stall sources; all three freeze F/D and bubble E in the same cycle
  always_comb begin
    lwstall     = MemtoRegE &&
                  (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD));
    branchstall = BranchD &&
                  (reg_hit(RegWriteE, WriteRegE, RsD) || reg_hit(RegWriteE, WriteRegE, RtD) ||
                   reg_hit(MemtoRegM, WriteRegM, RsD) || reg_hit(MemtoRegM, WriteRegM, RtD));
    mcstall     = pend_valid &&
                  (reg_hit(1'b1, pend_dest, RsD) || reg_hit(1'b1, pend_dest, RtD) || MultiCycleD);
    stall       = lwstall || branchstall || mcstall;
    StallF      = stall;
    StallD      = stall;
    FlushE      = stall;
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_br_cnt_q;

  // Saturating event counters for stall cycles and branch-induced stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q    <= 16'd0;
      flush_br_cnt_q <= 16'd0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (branchstall && (flush_br_cnt_q != 16'hFFFF)) begin
        flush_br_cnt_q <= flush_br_cnt_q + 16'd1;
      end
    end
  end

  assign StallCount       = stall_cnt_q;
  assign FlushBranchCount = flush_br_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (MC_LATENCY = 4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RsE, RtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, MultiCycleD, MultiCycleE;
  logic        StallF, StallD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        McBusy, McDone;
`ifdef HAZARD_PERF_EN
  logic [15:0] StallCount, FlushBranchCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LATENCY(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .RsD         (RsD),
    .RtD         (RtD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .MemtoRegM   (MemtoRegM),
    .BranchD     (BranchD),
    .MultiCycleD (MultiCycleD),
    .MultiCycleE (MultiCycleE),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .McBusy      (McBusy),
    .McDone      (McDone)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount       (StallCount),
    .FlushBranchCount (FlushBranchCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; MultiCycleD = 0; MultiCycleE = 0;
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #2;
    // Reset state
    chk("rst_mcbusy", 32'(McBusy), 32'd0);
    chk("rst_mcdone", 32'(McDone), 32'd0);
    chk("rst_stall",  32'({StallF, StallD, FlushE}), 32'd0);
    chk("rst_fwdae",  32'(ForwardAE), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_stallcnt", 32'(StallCount), 32'd0);
`endif
    #10;
    reset = 1'b1;
    tick();

    // Load-use stall and its register-0 exception
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5;
    #1;
    chk("lw_stall", 32'({StallF, StallD, FlushE}), 32'b111);
    RsD = 0; RtD = 5;
    #1;
    chk("lw_stall_rt", 32'(StallD), 32'd1);
    WriteRegE = 0; RsD = 0; RtD = 0;
    #1;
    chk("lw_r0", 32'({StallF, StallD, FlushE}), 32'b000);
    clear_inputs();

    // Forwarding priority M over W
    RegWriteM = 1; RegWriteW = 1; WriteRegM = 7; WriteRegW = 7; RsE = 7; RtE = 7;
    #1;
    chk("fwd_ae_mem", 32'(ForwardAE), 32'd2);
    chk("fwd_be_mem", 32'(ForwardBE), 32'd2);
    RegWriteM = 0;
    #1;
    chk("fwd_ae_wb", 32'(ForwardAE), 32'd1);
    WriteRegW = 0; RsE = 0;
    #1;
    chk("fwd_ae_r0", 32'(ForwardAE), 32'd0);
    RegWriteM = 1; WriteRegM = 7; RsD = 7; RtD = 4;
    #1;
    chk("fwd_ad", 32'({ForwardAD, ForwardBD}), 32'b10);
    chk("fwd_m_nostall", 32'(StallD), 32'd0);
    clear_inputs();
    tick();

    // Branch hazard: stall while producer in E, then forward from M
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
    #1;
    chk("br_stall", 32'({StallF, StallD, FlushE}), 32'b111);
    tick();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
    #1;
    chk("br_fwd_bd", 32'(ForwardBD), 32'd1);
    chk("br_nostall", 32'(StallD), 32'd0);
    MemtoRegM = 1;
    #1;
    chk("br_load_m_stall", 32'(StallD), 32'd1);
    clear_inputs();
    MultiCycleD = 1;
    #1;
    chk("mcd_idle_nostall", 32'(StallD), 32'd0);
    clear_inputs();
    tick();

    // Multi-cycle op: busy 4 cycles, done on the 4th, RsD=9 stalls meanwhile
    MultiCycleE = 1; WriteRegE = 9; RsD = 9;
    #1;
    chk("mc_pend_stall", 32'(StallD), 32'd1);
    chk("mc_pre_busy", 32'(McBusy), 32'd0);
    tick();
    MultiCycleE = 0; WriteRegE = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mc_busy", 32'(McBusy), 32'd1);
      chk("mc_done", 32'(McDone), (i == 3) ? 32'd1 : 32'd0);
      chk("mc_stall", 32'(StallD), 32'd1);
      tick();
    end
    chk("mc_idle_busy", 32'(McBusy), 32'd0);
    chk("mc_idle_done", 32'(McDone), 32'd0);
    chk("mc_idle_stall", 32'(StallD), 32'd0);
    clear_inputs();
    tick();

    // Reset in the 2nd BUSY cycle
    MultiCycleE = 1; WriteRegE = 9;
    tick();
    MultiCycleE = 0; WriteRegE = 0;
    tick();
    chk("rm_busy_before", 32'(McBusy), 32'd1);
    MultiCycleD = 1;
    #1;
    chk("rm_mcd_stall", 32'(StallD), 32'd1);
    MultiCycleD = 0; RsD = 9;
    #1;
    chk("rm_rs_stall", 32'(StallD), 32'd1);
    reset = 1'b0;
    #1;
    chk("rm_busy_after", 32'(McBusy), 32'd0);
    chk("rm_nostall", 32'(StallD), 32'd0);
    tick();
    chk("rm_hold_busy", 32'(McBusy), 32'd0);
    reset = 1'b1;
    clear_inputs();
    tick();
    chk("rm_post_busy", 32'(McBusy), 32'd0);

`ifdef HAZARD_PERF_EN
    // Counters were cleared by the reset above
    chk("perf_clr", 32'(StallCount), 32'd0);
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5;
    repeat (3) tick();
    chk("perf_stall3", 32'(StallCount), 32'd3);
    chk("perf_br0", 32'(FlushBranchCount), 32'd0);
    clear_inputs();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3;
    repeat (2) tick();
    chk("perf_br2", 32'(FlushBranchCount), 32'd2);
    chk("perf_stall5", 32'(StallCount), 32'd5);
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5;
    repeat (65530) tick();
    chk("perf_sat", 32'(StallCount), 32'hFFFF);
    tick();
    chk("perf_sat_hold", 32'(StallCount), 32'hFFFF);
    clear_inputs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
